bias_act_out: RTL and testbench
===============================

BIAS_ACT_OUT -- requirements
Module: bias_act_out

Interface
REQ-001 Parameter INW, default 64: signed accumulator width of the input stream; equals upstream OUTW.
REQ-002 Parameter OUTW, default 16: signed width of the activated output word.
REQ-003 Parameter BW, default 24: signed bias width.
REQ-004 Parameter M, default 17: number of output rows per vector result.
REQ-005 Parameter SHIFT, default 8: arithmetic right-shift (requantization) amount, 0..INW-1.
REQ-006 Parameter RELU_EN, default 1: 1 = ReLU then saturate; 0 = symmetric saturation only.
REQ-007 clk  input  1  sole clock; all state on rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 INPUT_TDATA  input  INW  signed dot-product result, row order 0..M-1.
REQ-010 INPUT_TVALID / INPUT_TREADY  input / output  1  AXI4-Stream handshake, input side.
REQ-011 bias_wr_en  input  1  bias register write strobe.
REQ-012 bias_addr  input  $clog2(M)  bias row index.
REQ-013 bias_data  input  BW  signed bias value.
REQ-014 OUTPUT_TDATA  output  OUTW  activated, saturated result.
REQ-015 OUTPUT_TVALID / OUTPUT_TREADY  output / input  1  AXI4-Stream handshake, output side.
REQ-016 OUTPUT_TLAST  output  1  high with row M-1 of each result.
REQ-017 sat_count  output  16  count of saturated outputs.

Function
REQ-018 Input beat accepted iff INPUT_TVALID && INPUT_TREADY; output beat transfers iff OUTPUT_TVALID && OUTPUT_TREADY.
REQ-019 Pipeline: S1 = bias add, S2 = shift/activate/saturate; each stage has a valid bit and loads only when empty or advancing in the same cycle.
REQ-020 INPUT_TREADY = !s1_valid || (s1 advances this cycle); the combinational path from OUTPUT_TREADY is permitted.
REQ-021 Latency: accepted beat appears on OUTPUT_TDATA exactly 2 cycles later when OUTPUT_TREADY is held high; sustained throughput is 1 beat/cycle.
REQ-022 While OUTPUT_TVALID=1 and OUTPUT_TREADY=0, OUTPUT_TDATA and OUTPUT_TLAST hold stable; no beat is dropped or duplicated.
REQ-023 Row counter increments on each input acceptance, wraps M-1 -> 0, and is held otherwise.
REQ-024 Row index and a last flag (row==M-1) travel with data through S1/S2.
REQ-025 S1: sum = INPUT_TDATA + sign-extended bias[row], computed at INW+1 bits with no overflow.
REQ-026 S2: shifted = sum >>> SHIFT (arithmetic, floor).
REQ-027 S2 with RELU_EN=1: result 0 if shifted<0; result 2^(OUTW-1)-1 if shifted > that value; otherwise shifted.
REQ-028 S2 with RELU_EN=0: clamp shifted to [-2^(OUTW-1), 2^(OUTW-1)-1].
REQ-029 sat_count increments when a beat that was clamped at either limit transfers on the output; ReLU zeroing is not counted; it holds at 16'hFFFF.
REQ-030 Bias write takes effect the next cycle; a beat entering S1 in the write cycle uses the old bias.
REQ-031 bias_addr >= M is ignored.

Reset
REQ-032 On reset assertion, immediately: OUTPUT_TVALID=0, OUTPUT_TDATA=0, OUTPUT_TLAST=0, stage valids=0, row counter=0, all biases=0, sat_count=0.
REQ-033 INPUT_TREADY=1 from the first clock edge after reset deassertion.
REQ-034 Reset mid-stream discards in-flight beats; the next accepted beat is row 0.

Structure
REQ-035 Shared package nn_pkg holds the default widths (INW, OUTW, BW, M) and the saturation-limit functions used by all stages.
REQ-036 One sub-module, act_sat: purely combinational shift/ReLU/clamp with a saturated flag output; all other logic is in bias_act_out.

Verification
REQ-037 Biases all 0, SHIFT=8, RELU_EN=1, inputs 256, 512, ..., 17*256 with ready high -> outputs 1..17, 2-cycle latency, TLAST only on the 17th.
REQ-038 Input -1000 with bias 0 -> output 0 and sat_count unchanged; input 2^40 -> output 32767 and sat_count +1.
REQ-039 RELU_EN=0, input -2^40 -> output -32768 and sat_count +1.
REQ-040 bias[3]=-512, input 1024 at row 3 -> output 2; a bias write in the same cycle as row-3 acceptance uses the old value.
REQ-041 Random OUTPUT_TREADY (50%), 3 back-to-back vectors -> 51 outputs in order, data stable while stalled, TLAST on beats 17, 34 and 51.
REQ-042 Reset asserted after row 5 is accepted -> TVALID drops at once; the next vector starts at row 0 with biases cleared.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared datapath widths and signed saturation limits for the neural-net
// output stages.
package nn_pkg;

   localparam int INW_D  = 64;
   localparam int OUTW_D = 16;
   localparam int BW_D   = 24;
   localparam int M_D    = 17;
   localparam int LIM_W  = 128;

   // Largest value representable in a w-bit two's complement word
   function automatic logic signed [LIM_W-1:0] sat_max(input int w);
      return (128'sd1 <<< (w - 1)) - 128'sd1;
   endfunction

   // Smallest value representable in a w-bit two's complement word
   function automatic logic signed [LIM_W-1:0] sat_min(input int w);
      return -(128'sd1 <<< (w - 1));
   endfunction

endpackage

// File: rtl/act_sat.sv
// Requantizes a widened sum by arithmetic right shift, then applies ReLU
// and/or a clamp to the signed output range, flagging clamped results.
module act_sat
   import nn_pkg::*;
#(
   parameter int INW     = INW_D,
   parameter int OUTW    = OUTW_D,
   parameter int SHIFT   = 8,
   parameter int RELU_EN = 1
) (
   input  logic signed [INW:0]    sum,
   output logic signed [OUTW-1:0] result,
   output logic                   saturated
);

   localparam logic signed [INW:0]    HI_LIM_C  = (INW+1)'(sat_max(OUTW));
   localparam logic signed [INW:0]    LO_LIM_C  = (INW+1)'(sat_min(OUTW));
   localparam logic signed [OUTW-1:0] OUT_MAX_C = OUTW'(sat_max(OUTW));
   localparam logic signed [OUTW-1:0] OUT_MIN_C = OUTW'(sat_min(OUTW));

   logic signed [INW:0] shifted_s;

   assign shifted_s = sum >>> SHIFT;

   // Activation and clamp selection; ReLU zeroing is not a saturation event
   always_comb begin
      result    = shifted_s[OUTW-1:0];
      saturated = 1'b0;
      if (RELU_EN != 0) begin
         if (shifted_s[INW]) begin
            result = {OUTW{1'b0}};
         end else if (shifted_s > HI_LIM_C) begin
            result    = OUT_MAX_C;
            saturated = 1'b1;
         end else begin
            result = shifted_s[OUTW-1:0];
         end
      end else begin
         if (shifted_s > HI_LIM_C) begin
            result    = OUT_MAX_C;
            saturated = 1'b1;
         end else if (shifted_s < LO_LIM_C) begin
            result    = OUT_MIN_C;
            saturated = 1'b1;
         end else begin
            result = shifted_s[OUTW-1:0];
         end
      end
   end

endmodule

// File: rtl/bias_act_out.sv
// Two-stage streaming bias add and activation: S1 adds the per-row bias,
// S2 holds the shifted, activated and saturated output beat.
module bias_act_out
   import nn_pkg::*;
#(
   parameter int INW     = INW_D,
   parameter int OUTW    = OUTW_D,
   parameter int BW      = BW_D,
   parameter int M       = M_D,
   parameter int SHIFT   = 8,
   parameter int RELU_EN = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic signed [INW-1:0]  INPUT_TDATA,
   input  logic                   INPUT_TVALID,
   output logic                   INPUT_TREADY,
   input  logic                   bias_wr_en,
   input  logic [$clog2(M)-1:0]   bias_addr,
   input  logic signed [BW-1:0]   bias_data,
   output logic signed [OUTW-1:0] OUTPUT_TDATA,
   output logic                   OUTPUT_TVALID,
   input  logic                   OUTPUT_TREADY,
   output logic                   OUTPUT_TLAST,
   output logic [15:0]            sat_count
);

   localparam int            AW         = $clog2(M);
   localparam logic [AW-1:0] LAST_ROW_C = AW'(M - 1);

   logic signed [BW-1:0]   bias_r [M];
   logic [AW-1:0]          row_r;
   logic                   s1_valid_r;
   logic signed [INW:0]    s1_sum_r;
   logic [AW-1:0]          s1_row_r;
   logic                   s2_sat_r;

   logic                   s2_ready_s;
   logic                   s1_fire_s;
   logic                   in_fire_s;
   logic                   out_fire_s;
   logic signed [INW:0]    in_ext_s;
   logic signed [INW:0]    bias_ext_s;
   logic signed [INW:0]    sum_s;
   logic signed [OUTW-1:0] act_result_s;
   logic                   act_sat_s;

   // S2 can take a new beat when empty or when its beat leaves this cycle
   assign s2_ready_s   = !OUTPUT_TVALID || OUTPUT_TREADY;
   assign s1_fire_s    = s1_valid_r && s2_ready_s;
   assign INPUT_TREADY = !s1_valid_r || s2_ready_s;
   assign in_fire_s    = INPUT_TVALID && INPUT_TREADY;
   assign out_fire_s   = OUTPUT_TVALID && OUTPUT_TREADY;

   assign in_ext_s   = (INW+1)'(INPUT_TDATA);
   assign bias_ext_s = (INW+1)'(bias_r[row_r]);
   assign sum_s      = in_ext_s + bias_ext_s;

   act_sat #(
      .INW     (INW),
      .OUTW    (OUTW),
      .SHIFT   (SHIFT),
      .RELU_EN (RELU_EN)
   ) u_act_sat (
      .sum       (s1_sum_r),
      .result    (act_result_s),
      .saturated (act_sat_s)
   );

   // Bias table; a write lands at the edge, so a same-cycle beat sees the old value
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < M; i++) begin
            bias_r[i] <= {BW{1'b0}};
         end
      end else if (bias_wr_en && (bias_addr <= LAST_ROW_C)) begin
         bias_r[bias_addr] <= bias_data;
      end
   end

   // Row position assigned to the next accepted beat
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         row_r <= {AW{1'b0}};
      end else if (in_fire_s) begin
         if (row_r == LAST_ROW_C) begin
            row_r <= {AW{1'b0}};
         end else begin
            row_r <= row_r + AW'(1'b1);
         end
      end
   end

   // S1: biased sum with its row index
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_r <= 1'b0;
         s1_sum_r   <= {(INW+1){1'b0}};
         s1_row_r   <= {AW{1'b0}};
      end else if (in_fire_s) begin
         s1_valid_r <= 1'b1;
         s1_sum_r   <= sum_s;
         s1_row_r   <= row_r;
      end else if (s1_fire_s) begin
         s1_valid_r <= 1'b0;
      end
   end

   // S2: registered output beat, held stable while the sink stalls
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         OUTPUT_TVALID <= 1'b0;
         OUTPUT_TDATA  <= {OUTW{1'b0}};
         OUTPUT_TLAST  <= 1'b0;
         s2_sat_r      <= 1'b0;
      end else if (s1_fire_s) begin
         OUTPUT_TVALID <= 1'b1;
         OUTPUT_TDATA  <= act_result_s;
         OUTPUT_TLAST  <= (s1_row_r == LAST_ROW_C);
         s2_sat_r      <= act_sat_s;
      end else if (OUTPUT_TREADY) begin
         OUTPUT_TVALID <= 1'b0;
      end
   end

   // Count clamped beats as they leave, sticking at full scale
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sat_count <= 16'd0;
      end else if (out_fire_s && s2_sat_r && (sat_count != 16'hFFFF)) begin
         sat_count <= sat_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_bias_act_out.sv
// Randomized and directed bench for bias_act_out, one ReLU and one symmetric
// instance sharing stimulus, checked against a queue-based arithmetic model.
module tb_bias_act_out;

   localparam int M = 17;

   typedef struct {
      logic signed [15:0] d_relu;
      logic signed [15:0] d_sym;
      bit                 last;
      bit                 s_relu;
      bit                 s_sym;
   } exp_t;

   logic               clk = 1'b0;
   logic               reset;
   logic signed [63:0] INPUT_TDATA;
   logic               INPUT_TVALID;
   logic               INPUT_TREADY, INPUT_TREADY_b;
   logic               bias_wr_en;
   logic [4:0]         bias_addr;
   logic signed [23:0] bias_data;
   logic signed [15:0] OUTPUT_TDATA, OUTPUT_TDATA_b;
   logic               OUTPUT_TVALID, OUTPUT_TVALID_b;
   logic               OUTPUT_TREADY;
   logic               OUTPUT_TLAST, OUTPUT_TLAST_b;
   logic [15:0]        sat_count, sat_count_b;

   int n_checks = 0;
   int n_fail   = 0;
   int rdy_mode = 1;

   logic signed [23:0] bias_m [M];
   int                 row_m  = 0;
   int                 sat0_m = 0;
   int                 sat1_m = 0;
   exp_t               exp_q[$];
   logic signed [15:0] got_q[$];
   logic signed [15:0] gotb_q[$];
   bit                 gotl_q[$];

   always #5 clk = ~clk;

   bias_act_out #(.SHIFT(8), .RELU_EN(1)) u_relu (
      .clk(clk), .reset(reset),
      .INPUT_TDATA(INPUT_TDATA), .INPUT_TVALID(INPUT_TVALID), .INPUT_TREADY(INPUT_TREADY),
      .bias_wr_en(bias_wr_en), .bias_addr(bias_addr), .bias_data(bias_data),
      .OUTPUT_TDATA(OUTPUT_TDATA), .OUTPUT_TVALID(OUTPUT_TVALID),
      .OUTPUT_TREADY(OUTPUT_TREADY), .OUTPUT_TLAST(OUTPUT_TLAST), .sat_count(sat_count)
   );

   bias_act_out #(.SHIFT(8), .RELU_EN(0)) u_sym (
      .clk(clk), .reset(reset),
      .INPUT_TDATA(INPUT_TDATA), .INPUT_TVALID(INPUT_TVALID), .INPUT_TREADY(INPUT_TREADY_b),
      .bias_wr_en(bias_wr_en), .bias_addr(bias_addr), .bias_data(bias_data),
      .OUTPUT_TDATA(OUTPUT_TDATA_b), .OUTPUT_TVALID(OUTPUT_TVALID_b),
      .OUTPUT_TREADY(OUTPUT_TREADY), .OUTPUT_TLAST(OUTPUT_TLAST_b), .sat_count(sat_count_b)
   );

   task automatic chk(input string nm, input logic signed [127:0] act,
                      input logic signed [127:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %0d, required %0d", nm, act, req);
      end
   endtask

   // Arithmetic reference: floor-divide by 256, then ReLU+clamp or plain clamp
   function automatic void act_model(input logic signed [127:0] sum,
                                     output logic signed [15:0] relu_v, output bit relu_s,
                                     output logic signed [15:0] sym_v, output bit sym_s);
      logic signed [127:0] q;
      q = sum >>> 8;
      relu_s = 1'b0;
      sym_s  = 1'b0;
      if (q < 0)          relu_v = 16'sd0;
      else if (q > 32767) begin relu_v = 16'sd32767; relu_s = 1'b1; end
      else                relu_v = q[15:0];
      if (q > 32767)       begin sym_v = 16'sd32767;  sym_s = 1'b1; end
      else if (q < -32768) begin sym_v = -16'sd32768; sym_s = 1'b1; end
      else                 sym_v = q[15:0];
   endfunction

   initial begin
      OUTPUT_TREADY = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         OUTPUT_TREADY = (rdy_mode == 2) ? 1'($urandom_range(1, 0)) : (rdy_mode == 1);
      end
   end

   // Scoreboard: every cycle compare outputs to the model queue head, then log handshakes
   always @(negedge clk) begin
      exp_t                e;
      logic signed [127:0] sum;
      if (reset) begin
         chk("reset_tvalid", OUTPUT_TVALID, 0);
         chk("reset_tdata", OUTPUT_TDATA, 0);
         chk("reset_tlast", OUTPUT_TLAST, 0);
         chk("reset_sat_count", sat_count, 0);
         exp_q.delete();
         row_m  = 0;
         sat0_m = 0;
         sat1_m = 0;
         for (int i = 0; i < M; i++) bias_m[i] = 24'sd0;
      end else begin
         chk("sat_count", sat_count, sat0_m);
         chk("sat_count_sym", sat_count_b, sat1_m);
         chk("tready_pair", INPUT_TREADY_b, INPUT_TREADY);
         chk("tvalid_pair", OUTPUT_TVALID_b, OUTPUT_TVALID);
         if (OUTPUT_TVALID) begin
            chk("beat_expected_depth", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               e = exp_q[0];
               chk("tdata_relu", OUTPUT_TDATA, e.d_relu);
               chk("tdata_sym", OUTPUT_TDATA_b, e.d_sym);
               chk("tlast", OUTPUT_TLAST, e.last);
               chk("tlast_sym", OUTPUT_TLAST_b, e.last);
               if (OUTPUT_TREADY) begin
                  void'(exp_q.pop_front());
                  if (e.s_relu && sat0_m < 65535) sat0_m++;
                  if (e.s_sym && sat1_m < 65535) sat1_m++;
                  got_q.push_back(OUTPUT_TDATA);
                  gotb_q.push_back(OUTPUT_TDATA_b);
                  gotl_q.push_back(OUTPUT_TLAST);
               end
            end
         end
         if (INPUT_TVALID && INPUT_TREADY) begin
            sum = INPUT_TDATA;
            sum = sum + bias_m[row_m];
            act_model(sum, e.d_relu, e.s_relu, e.d_sym, e.s_sym);
            e.last = (row_m == M - 1);
            exp_q.push_back(e);
            row_m = (row_m == M - 1) ? 0 : row_m + 1;
         end
         if (bias_wr_en && bias_addr < M) bias_m[bias_addr] = bias_data;
      end
   end

   task automatic send(input logic signed [63:0] d);
      bit acc = 1'b0;
      INPUT_TVALID = 1'b1;
      INPUT_TDATA  = d;
      for (int n = 0; n < 200 && !acc; n++) begin
         @(negedge clk);
         acc = INPUT_TREADY;
         @(posedge clk);
         #1;
      end
      chk("send_accepted_in_budget", acc, 1);
   endtask

   task automatic idle();
      INPUT_TVALID = 1'b0;
   endtask

   task automatic wr(input logic [4:0] a, input logic signed [23:0] d);
      bias_wr_en = 1'b1;
      bias_addr  = a;
      bias_data  = d;
      @(posedge clk);
      #1;
      bias_wr_en = 1'b0;
   endtask

   task automatic drain();
      bit done = 1'b0;
      for (int n = 0; n < 2000 && !done; n++) begin
         @(negedge clk);
         done = (exp_q.size() == 0) && !OUTPUT_TVALID;
         @(posedge clk);
         #1;
      end
      chk("drain_in_budget", done, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic signed [15:0] rv, sv;
      bit                 rs, ss;
      logic signed [63:0] r;
      int                 base, nl;

      reset = 1'b1;
      INPUT_TVALID = 1'b0;
      INPUT_TDATA  = 64'sd0;
      bias_wr_en   = 1'b0;
      bias_addr    = 5'd0;
      bias_data    = 24'sd0;

      act_model(128'sd1024 - 128'sd512, rv, rs, sv, ss);
      chk("model_bias_row3", rv, 2);
      act_model(-128'sd1000, rv, rs, sv, ss);
      chk("model_neg_relu", rv, 0);
      chk("model_neg_relu_sat", rs, 0);
      act_model(128'sd1 <<< 40, rv, rs, sv, ss);
      chk("model_big_pos", rv, 32767);
      chk("model_big_pos_sat", rs, 1);
      act_model(-(128'sd1 <<< 40), rv, rs, sv, ss);
      chk("model_big_neg_sym", sv, -32768);
      chk("model_big_neg_sym_sat", ss, 1);

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("tready_after_reset", INPUT_TREADY, 1);
      @(posedge clk);
      #1;

      // Ramp vector: 256*k -> k, two-cycle latency, TLAST on the last row
      base = got_q.size();
      send(64'sd256);
      chk("latency_cycle1_tvalid", OUTPUT_TVALID, 0);
      send(64'sd512);
      chk("latency_cycle2_tvalid", OUTPUT_TVALID, 1);
      chk("latency_cycle2_tdata", OUTPUT_TDATA, 1);
      for (int k = 3; k <= 17; k++) send(64'(k * 256));
      idle();
      drain();
      chk("ramp_count", got_q.size() - base, 17);
      for (int k = 0; k < 17; k++) begin
         chk("ramp_data", got_q[base + k], k + 1);
         chk("ramp_last", gotl_q[base + k], (k == 16));
      end

      // ReLU zeroing vs. positive saturation, then negative saturation
      base = got_q.size();
      send(-64'sd1000);
      idle();
      drain();
      chk("relu_neg_data", got_q[base], 0);
      chk("relu_neg_sat_count", sat_count, 0);
      send(64'sd1 <<< 40);
      idle();
      drain();
      chk("pos_sat_data", got_q[base + 1], 32767);
      chk("pos_sat_count", sat_count, 1);
      send(-(64'sd1 <<< 40));
      idle();
      drain();
      chk("neg_sat_sym_data", gotb_q[base + 2], -32768);
      chk("neg_sat_sym_count", sat_count_b, 2);
      chk("neg_sat_relu_data", got_q[base + 2], 0);

      // Bias on row 3, same-cycle write uses old value, out-of-range writes ignored
      base = got_q.size();
      wr(5'd3, -24'sd512);
      send(64'sd1024);
      for (int k = 0; k < 16; k++) send(64'sd1024);
      bias_wr_en = 1'b1;
      bias_addr  = 5'd3;
      bias_data  = 24'sd4096;
      send(64'sd1024);
      bias_wr_en = 1'b0;
      idle();
      wr(5'd17, 24'sd77777);
      wr(5'd31, -24'sd99999);
      for (int k = 0; k < 17; k++) send(64'sd1024);
      idle();
      drain();
      chk("bias_row3_data", got_q[base], 2);
      chk("bias_row4_data", got_q[base + 1], 4);
      chk("bias_same_cycle_old", got_q[base + 17], 2);
      chk("bias_new_value", got_q[base + 34], 20);

      // Mid-stream reset after row 5 drops TVALID at once and clears biases
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      wr(5'd3, 24'sd4096);
      for (int k = 0; k < 6; k++) send(64'((k + 1) * 256));
      idle();
      chk("pre_reset_tvalid", OUTPUT_TVALID, 1);
      reset = 1'b1;
      #1;
      chk("async_reset_tvalid", OUTPUT_TVALID, 0);
      chk("async_reset_tlast", OUTPUT_TLAST, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      base = got_q.size();
      for (int k = 1; k <= 17; k++) send(64'(k * 256));
      idle();
      drain();
      chk("post_reset_count", got_q.size() - base, 17);
      chk("post_reset_row0", got_q[base], 1);
      chk("post_reset_row3_no_bias", got_q[base + 3], 4);
      chk("post_reset_last", gotl_q[base + 16], 1);

      // Random biases, random data, random sink stalls over three vectors
      for (int k = 0; k < M; k++) wr(5'(k), 24'($urandom()));
      rdy_mode = 2;
      base = got_q.size();
      for (int k = 0; k < 51; k++) begin
         r = {$urandom(), $urandom()};
         r = r >>> $urandom_range(60, 12);
         send(r);
      end
      idle();
      drain();
      rdy_mode = 1;
      chk("random_count", got_q.size() - base, 51);
      nl = 0;
      for (int k = 0; k < 51; k++) nl += int'(gotl_q[base + k]);
      chk("random_last_total", nl, 3);
      chk("random_last_17", gotl_q[base + 16], 1);
      chk("random_last_34", gotl_q[base + 33], 1);
      chk("random_last_51", gotl_q[base + 50], 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
